ledger_datapath: RTL and testbench

LEDGER_DATAPATH -- requirements
Module: ledger_datapath

---
 rtl/ledger_datapath.sv | 141 ++++++++++++++
 tb/tb_ledger_datapath.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ledger_datapath.sv
// ledger_datapath: single-transfer engine over a bank of six 8-bit balances.
// It fetches the bank from memory, validates the transfer, applies it in one
// cycle, then waits for the memory controller to write the bank back.
module ledger_datapath (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  sender,
  input  logic [2:0]  receiver,
  input  logic [7:0]  amount,
  input  logic        load_registers,
  input  logic [47:0] mem_q,
  input  logic        mem_done,
  output logic        load_memory,
  output logic [47:0] datapath_out,
  output logic [2:0]  process,
  output logic        tx_ok,
  output logic        tx_err,
  output logic [2:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_CHECK  = 3'd2,
    S_UPDATE = 3'd3,
    S_WRITE  = 3'd4,
    S_REJECT = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [5:0][7:0] bank_q, bank_d;
  logic [2:0]      snd_q, snd_d, rcv_q, rcv_d, err_q, err_d;
  logic [7:0]      amt_q, amt_d, cnt_q, cnt_d;
  logic            seen_q, seen_d, low_q, low_d;
  logic [7:0]      bal_s, bal_r;

  // Next-state, bank update and transfer validation.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    snd_d   = snd_q;
    rcv_d   = rcv_q;
    amt_d   = amt_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    low_d   = low_q;
    // Index by comparison so an out-of-range index reads 0 instead of X.
    bal_s = '0;
    bal_r = '0;
    for (int i = 0; i < 6; i++) begin
      if (snd_q == 3'(i)) bal_s = bank_q[i];
      if (rcv_q == 3'(i)) bal_r = bank_q[i];
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snd_d   = sender;
          rcv_d   = receiver;
          amt_d   = amount;
          err_d   = 3'd0;
          cnt_d   = 8'd0;
          seen_d  = 1'b0;
          low_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        cnt_d = 8'(cnt_q + 8'd1);
        if (load_registers) begin
          bank_d = mem_q;
          seen_d = 1'b1;
        end else if (seen_q) begin
          state_d = S_CHECK;
        end else if (cnt_q == 8'd254) begin
          // This is the 255th fetch cycle with no data: give up.
          state_d = S_REJECT;
          err_d   = 3'd5;
        end
      end
      S_CHECK: begin
        state_d = S_REJECT;
        if (snd_q > 3'd5 || rcv_q > 3'd5 || snd_q == rcv_q) err_d = 3'd1;
        else if (amt_q == 8'd0)                             err_d = 3'd2;
        else if (bal_s < amt_q)                             err_d = 3'd3;
        else if (({1'b0, bal_r} + {1'b0, amt_q}) > 9'd255)  err_d = 3'd4;
        else                                                state_d = S_UPDATE;
      end
      S_UPDATE: begin
        // Checks above guarantee neither side wraps.
        for (int i = 0; i < 6; i++) begin
          if (snd_q == 3'(i))      bank_d[i] = 8'(bank_q[i] - amt_q);
          else if (rcv_q == 3'(i)) bank_d[i] = 8'(bank_q[i] + amt_q);
        end
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (!mem_done)  low_d   = 1'b1;
        else if (low_q) state_d = S_IDLE;
      end
      S_REJECT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      snd_q   <= '0;
      rcv_q   <= '0;
      amt_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      low_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      snd_q   <= snd_d;
      rcv_q   <= rcv_d;
      amt_q   <= amt_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      low_q   <= low_d;
    end
  end

  assign process      = state_q;
  assign datapath_out = bank_q;
  assign err_code     = err_q;
  assign load_memory  = (state_q == S_FETCH) && !seen_q;
  assign tx_err       = (state_q == S_REJECT);
  // Commit pulse lands in the completing cycle itself; a reset in that same
  // cycle aborts the transfer, so it suppresses the pulse.
  assign tx_ok        = resetn && (state_q == S_WRITE) && low_q && mem_done;

endmodule

// File: tb/tb_ledger_datapath.sv
// Directed bench for ledger_datapath: a transaction-level model of the
// balances and rejection rules drives a per-cycle expected-output timeline.
module tb_ledger_datapath;
  logic        clock = 1'b0;
  logic        resetn, start, load_registers, mem_done;
  logic [2:0]  sender, receiver;
  logic [7:0]  amount;
  logic [47:0] mem_q;
  logic        load_memory, tx_ok, tx_err;
  logic [47:0] datapath_out;
  logic [2:0]  process, err_code;

  ledger_datapath dut (
    .clock(clock), .resetn(resetn), .start(start), .sender(sender),
    .receiver(receiver), .amount(amount), .load_registers(load_registers),
    .mem_q(mem_q), .mem_done(mem_done), .load_memory(load_memory),
    .datapath_out(datapath_out), .process(process), .tx_ok(tx_ok),
    .tx_err(tx_err), .err_code(err_code)
  );

  always #5 clock = ~clock;

  int total = 0, bad = 0, ok_seen = 0, ok_exp = 0, lm_cnt = 0;
  logic       chk_en = 1'b0;
  logic [2:0] e_proc, e_code;
  logic       e_lm, e_ok, e_err;
  logic [7:0] mb [6];

  function automatic logic [47:0] packed_bank();
    logic [47:0] v = '0;
    for (int i = 0; i < 6; i++) v[8*i +: 8] = mb[i];
    return v;
  endfunction

  // Rejection rules in priority order; 0 means the transfer is allowed.
  function automatic logic [2:0] judge(input int s, input int r, input int a);
    if (s > 5 || r > 5 || s == r) return 3'd1;
    if (a == 0) return 3'd2;
    if (int'(mb[s]) < a) return 3'd3;
    if (int'(mb[r]) + a > 255) return 3'd4;
    return 3'd0;
  endfunction

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle: compare all outputs with the model's expectations.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("process", 48'(process), 48'(e_proc));
      chk("load_memory", 48'(load_memory), 48'(e_lm));
      chk("tx_ok", 48'(tx_ok), 48'(e_ok));
      chk("tx_err", 48'(tx_err), 48'(e_err));
      chk("err_code", 48'(err_code), 48'(e_code));
      chk("datapath_out", datapath_out, packed_bank());
      if (tx_ok) ok_seen++;
      if (load_memory) lm_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    e_proc = 3'd0; e_lm = 1'b0; e_ok = 1'b0; e_err = 1'b0;
  endtask

  // One transaction from an IDLE cycle back to the next IDLE cycle.
  task automatic run_tx(input int s, input int r, input int a, input logic [47:0] mq,
                        input int wait_n, input bit busy, input bit rst_in_write);
    logic [2:0] code;
    start = 1'b1; sender = 3'(s); receiver = 3'(r); amount = 8'(a);
    load_registers = 1'b0; mem_done = 1'b1;
    set_idle();
    cyc();
    start = busy; sender = 3'd0; receiver = 3'd0; amount = 8'd0;
    e_code = 3'd0; e_proc = 3'd1; e_lm = 1'b1;
    repeat (wait_n) cyc();
    load_registers = 1'b1; mem_q = mq;
    cyc();
    for (int i = 0; i < 6; i++) mb[i] = mq[8*i +: 8];
    load_registers = 1'b0; mem_q = ~mq; e_lm = 1'b0;
    cyc();
    e_proc = 3'd2;
    code = judge(s, r, a);
    cyc();
    if (code != 3'd0) begin
      e_proc = 3'd5; e_err = 1'b1; e_code = code;
      cyc();
      start = 1'b0; set_idle();
      return;
    end
    e_proc = 3'd3;
    cyc();
    mb[s] = 8'(int'(mb[s]) - a);
    mb[r] = 8'(int'(mb[r]) + a);
    e_proc = 3'd4; mem_done = 1'b1;
    cyc();
    mem_done = 1'b0;
    cyc();
    if (rst_in_write) begin
      mem_done = 1'b1; resetn = 1'b0;
      cyc();
      resetn = 1'b1; start = 1'b0;
      for (int i = 0; i < 6; i++) mb[i] = 8'd0;
      e_code = 3'd0; set_idle();
      return;
    end
    cyc();
    mem_done = 1'b1; e_ok = 1'b1; ok_exp++;
    cyc();
    start = 1'b0; set_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lm0;
    for (int i = 0; i < 6; i++) mb[i] = 8'd0;
    e_code = 3'd0; set_idle();
    resetn = 1'b0; start = 1'b1; load_registers = 1'b1; mem_done = 1'b1;
    sender = 3'd0; receiver = 3'd1; amount = 8'd1; mem_q = 48'hFFFF_FFFF_FFFF;
    cyc(); cyc();
    chk_en = 1'b1;
    cyc();
    resetn = 1'b1; start = 1'b0;
    // IDLE with a capture strobe: bank must not move.
    cyc();
    load_registers = 1'b0;

    run_tx(0, 1, 40, 48'h0000_0000_1E64, 2, 1'b0, 1'b0);
    chk("pin_ok_bank", datapath_out, 48'h0000_0000_463C);
    run_tx(0, 1, 101, 48'h0000_0000_1E64, 0, 1'b0, 1'b0);
    chk("pin_insufficient", {45'd0, err_code}, 48'd3);
    chk("pin_reject_bank", datapath_out, 48'h0000_0000_1E64);
    run_tx(0, 1, 10, 48'h0000_0000_FA64, 0, 1'b0, 1'b0);
    chk("pin_overflow", {45'd0, err_code}, 48'd4);
    run_tx(2, 2, 5, 48'h0000_0000_FA64, 1, 1'b0, 1'b0);
    chk("pin_same_acct", {45'd0, err_code}, 48'd1);
    run_tx(0, 1, 0, 48'h0000_0000_FA64, 0, 1'b0, 1'b0);
    chk("pin_zero_amt", {45'd0, err_code}, 48'd2);
    run_tx(6, 1, 5, 48'h0000_0000_FA64, 0, 1'b0, 1'b0);
    run_tx(0, 1, 5, 48'h0000_0000_FA64, 0, 1'b0, 1'b0);
    chk("pin_exact_255", datapath_out, 48'h0000_0000_FF5F);
    run_tx(2, 3, 7, 48'h0000_1007_0000, 3, 1'b1, 1'b0);
    chk("pin_drain", datapath_out, 48'h0000_1700_0000);
    run_tx(5, 4, 200, 48'hC800_0000_0000, 0, 1'b1, 1'b0);
    chk("pin_acct5", datapath_out, 48'h00C8_0000_0000);

    // Fetch timeout: no load_registers at all.
    lm0 = lm_cnt;
    start = 1'b1; sender = 3'd0; receiver = 3'd1; amount = 8'd1;
    cyc();
    start = 1'b0; e_code = 3'd0; e_proc = 3'd1; e_lm = 1'b1;
    repeat (255) cyc();
    e_proc = 3'd5; e_lm = 1'b0; e_err = 1'b1; e_code = 3'd5;
    cyc();
    set_idle();
    chk("timeout_lm_cycles", 48'(lm_cnt - lm0), 48'd255);

    run_tx(0, 1, 40, 48'h0000_0000_1E64, 0, 1'b0, 1'b1);
    chk("pin_reset_bank", datapath_out, 48'd0);
    run_tx(0, 1, 40, 48'h0000_0000_1E64, 1, 1'b0, 1'b0);
    chk("pin_after_reset", datapath_out, 48'h0000_0000_463C);
    cyc();
    chk("tx_ok_count", 48'(ok_seen), 48'(ok_exp));
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
